// File: rtl/demux_1_16_1bit_reg.sv
// demux_1_16_1bit_reg: registered 1-to-16 single-bit demux with addressed and auto-scan lane selection
// Ports: clk, rst (sync, active-high); IN serial bit; VALID capture enable; S lane select (MODE=0);
//        MODE 0=addressed 1=scan; CLR sync clear; X[15:0] held lanes; PTR scan pointer;
//        FRAME_DONE one-cycle pulse once lane 15 is written in scan mode.
// Macro DEMUX_ZERO_UNSEL_EN: addressed writes zero every unselected lane (X = IN << S).
module demux_1_16_1bit_reg #(
    parameter logic [15:0] RESET_VAL  = 16'h0000,
    parameter logic [3:0]  SCAN_START = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN,
    input  logic        VALID,
    input  logic [3:0]  S,
    input  logic        MODE,
    input  logic        CLR,
    output logic [15:0] X,
    output logic [3:0]  PTR,
    output logic        FRAME_DONE
);
    logic        mode_q;
    logic        mode_chg;
    logic [3:0]  cur;
    logic [3:0]  lane;
    logic [15:0] x_nxt;
    always_comb begin
        mode_chg = MODE != mode_q;
        // a mode change restarts the scan at SCAN_START even for a capture in that same cycle
        cur      = mode_chg ? SCAN_START : PTR;
        lane     = MODE ? cur : S;
`ifdef DEMUX_ZERO_UNSEL_EN
        x_nxt    = MODE ? X : 16'h0000;
`else
        x_nxt    = X;
`endif
        x_nxt[lane] = IN;
    end
    always_ff @(posedge clk) begin
        if (rst || CLR) begin
            X          <= RESET_VAL;
            PTR        <= SCAN_START;
            FRAME_DONE <= 1'b0;
            mode_q     <= MODE;
        end else begin
            mode_q     <= MODE;
            X          <= VALID ? x_nxt : X;
            PTR        <= (VALID && MODE) ? cur + 4'd1 : cur;
            FRAME_DONE <= VALID && MODE && (cur == 4'd15);
        end
    end
endmodule
